ysyx_23060111_wbarb: RTL
========================

YSYX_23060111_WBARB -- requirements
Module: ysyx_23060111_wbarb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have ports, in this order (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- a_valid  in  1  requester A (EXU result) offers a write.
- a_ready  out  1  A accepted this cycle.
- a_rd  in  ADDR_WIDTH  A destination.
- a_data  in  DATA_WIDTH  A data.
- b_valid  in  1  requester B (LSU load) offers a write.
- b_ready  out  1  B accepted this cycle.
- b_rd  in  ADDR_WIDTH  B destination.
- b_data  in  DATA_WIDTH  B data.
- iss_valid  in  1  issue of an instruction that will write iss_rd.
- iss_rd  in  ADDR_WIDTH  issued destination.
- qaddr1, qaddr2  in  ADDR_WIDTH  hazard query addresses.
- busy1, busy2  out  1  queried register has a write pending.
- rf_wen  out  1  register-file write enable.
- rf_waddr  out  ADDR_WIDTH  register-file write address.
- rf_wdata  out  DATA_WIDTH  register-file write data.
- byp_hit1, byp_hit2  out  1  qaddrN matches the write committing this cycle (macro only).
- byp_data  out  DATA_WIDTH  rf_wdata forwarded (macro only).

Function
REQ-004 SHALL share the single register-file write port between A and B; a transfer occurs when valid and ready are both 1 at a rising edge.
REQ-005 SHALL compute ready combinationally: a single valid requester gets ready=1; with both valid, only the priority-pointer holder gets ready=1.
REQ-006 SHALL keep a 1-bit round-robin pointer (0=A, 1=B); after a granted conflict, the pointer moves to the loser; a single-requester grant does not move it.
REQ-007 SHALL register the winner: rf_wen/rf_waddr/rf_wdata take the granted rd/data on the edge after the handshake (latency 1 cycle); with no grant, rf_wen=0 and addr/data hold.
REQ-008 SHALL accept a request with rd=0 (ready asserted) but drive rf_wen=0 for it.
REQ-009 SHALL assert valid-side ready regardless of downstream state; the write port never back-pressures (throughput one write per cycle).
REQ-010 SHALL hold a 2**ADDR_WIDTH-bit busy scoreboard; busy[0] is always 0.
REQ-011 SHALL set busy[iss_rd] on the edge where iss_valid=1 and iss_rd!=0.
REQ-012 SHALL clear busy[rf_waddr] on the edge where rf_wen=1.
REQ-013 SHALL let set win when set and clear target the same register on one edge.
REQ-014 SHALL drive busy1=busy[qaddr1], busy2=busy[qaddr2] combinationally from current register state.
REQ-015 SHALL not check whether a write has a matching issue; an unissued write still clears (no-op if already 0).

Reset
REQ-016 SHALL on rst=1, asynchronously: rf_wen=0, rf_waddr=0, rf_wdata=0, pointer=0 (A priority), all busy bits=0.
REQ-017 SHALL drive a_ready=b_ready=0 while rst=1; a request in flight at reset is discarded.
REQ-018 SHALL resume arbitration on the first rising edge after rst deasserts.

Configuration
REQ-019 SHALL honour macro YSYX_23060111_WB_BYPASS_EN.
REQ-020 With the macro defined: byp_hitN=rf_wen && rf_waddr!=0 && qaddrN==rf_waddr, byp_data=rf_wdata; busyN is forced 0 whenever byp_hitN=1.
REQ-021 Without the macro: byp_hit1=byp_hit2=0, byp_data=0, busyN purely from the scoreboard.

Verification
REQ-022 A only: a_valid=1, a_rd=5, a_data=0x11 -> a_ready=1 same cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x11.
REQ-023 Conflict after reset: A(rd=3,0xAA) and B(rd=4,0xBB) held valid 2 cycles -> cycle 1 grants A, cycle 2 grants B; rf writes 3/0xAA then 4/0xBB.
REQ-024 Zero register: b_valid=1, b_rd=0, b_data=0xFF -> b_ready=1, rf_wen stays 0.
REQ-025 Scoreboard: iss_rd=7 issued; qaddr1=7 -> busy1=1 next cycle; A writes rd=7 -> busy1=0 the cycle after rf_wen; issue rd=7 on the commit edge -> busy1 stays 1.
REQ-026 Bypass (macro on): rf_wen=1, rf_waddr=9, rf_wdata=0x1234, qaddr2=9 -> byp_hit2=1, byp_data=0x1234, busy2=0; macro off -> byp_hit2=0.
REQ-027 Reset mid-traffic: rst pulsed while A valid and busy[6]=1 -> rf_wen=0, a_ready=0, busy2(qaddr2=6)=0 immediately, pointer back to A.

Source files
------------

// File: rtl/ysyx_23060111_wbarb.sv
// Write-back arbiter: round-robin share of one register-file write port between
// EXU (A) and LSU (B), with a pending-write scoreboard. Optional forwarding via YSYX_23060111_WB_BYPASS_EN.
module ysyx_23060111_wbarb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_rd,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_rd,
    input  logic [DATA_WIDTH-1:0] b_data,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic [ADDR_WIDTH-1:0] qaddr1,
    input  logic [ADDR_WIDTH-1:0] qaddr2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  byp_hit1,
    output logic                  byp_hit2,
    output logic [DATA_WIDTH-1:0] byp_data
);
    localparam int NREG = 2 ** ADDR_WIDTH;

    logic            ptr;
    logic            grant_a;
    logic            grant_b;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    // ptr=0 gives A priority on a conflict, ptr=1 gives B priority.
    always_comb begin
        grant_a = !rst && a_valid && (!b_valid || !ptr);
        grant_b = !rst && b_valid && (!a_valid || ptr);
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= 1'b0;
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            if (a_valid && b_valid)
                ptr <= grant_a;
            if (grant_a) begin
                rf_wen   <= (a_rd != '0);
                rf_waddr <= a_rd;
                rf_wdata <= a_data;
            end else if (grant_b) begin
                rf_wen   <= (b_rd != '0);
                rf_waddr <= b_rd;
                rf_wdata <= b_data;
            end else begin
                rf_wen <= 1'b0;
            end
        end
    end

    // Clear applied before set so a same-edge issue keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (rf_wen)
            busy_nxt[rf_waddr] = 1'b0;
        if (iss_valid && iss_rd != '0)
            busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

`ifdef YSYX_23060111_WB_BYPASS_EN
    assign byp_hit1 = rf_wen && (rf_waddr != '0) && (qaddr1 == rf_waddr);
    assign byp_hit2 = rf_wen && (rf_waddr != '0) && (qaddr2 == rf_waddr);
    assign byp_data = rf_wdata;
    assign busy1    = busy[qaddr1] && !byp_hit1;
    assign busy2    = busy[qaddr2] && !byp_hit2;
`else
    assign byp_hit1 = 1'b0;
    assign byp_hit2 = 1'b0;
    assign byp_data = '0;
    assign busy1    = busy[qaddr1];
    assign busy2    = busy[qaddr2];
`endif

endmodule
